instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Instruction-fetch stage that produces the instruction / next-PC pair consumed by the IF/ID pipeline register.
- Owns the PC and issues one word fetch at a time to instruction memory over a request/grant/response handshake.
- Buffers one returned instruction while the decode side stalls.
- Applies branch/jump redirects, flushing any in-flight or buffered fetch.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction driven on instr_out whenever instr_valid=0.

Ports:
clk  input  1  single clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hazard-unit hold; the current output must not be consumed.
redirect  input  1  taken branch/jump this cycle.
redirect_pc  input  32  target PC, valid with redirect.
imem_req  output  1  fetch request.
imem_addr  output  32  word address of the request (= pc).
imem_gnt  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  response data valid.
imem_rdata  input  32  fetched instruction.
instr_out  output  32  instruction to IF/ID.
next_pc_out  output  32  PC+4 of instr_out.
instr_valid  output  1  instr_out holds a real instruction.
pc_out  output  32  current fetch PC.

Behaviour:
Reset (asynchronous):
- pc=RESET_PC, state=REQ.
- instr_out=NOP_WORD, next_pc_out=0, instr_valid=0, hold buffer empty.
- imem_req is forced 0 while reset=1.
- Instruction memory is reset with this block, so no response from before reset arrives afterwards.

Output slot:
- The slot is free when instr_valid=0 or stall=0 (contents consumed this cycle).
- On consume with no replacement: instr_valid<=0, instr_out<=NOP_WORD, next_pc_out holds its value.

State machine: REQ, WAIT, HOLD, DRAIN. Redirect has priority over every other event.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt: fetch_pc<=pc, pc<=pc+4, go to WAIT.
  - On redirect with imem_gnt: pc<=redirect_pc, go to DRAIN.
  - On redirect without imem_gnt: pc<=redirect_pc, stay in REQ.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with slot free: instr_out<=imem_rdata, next_pc_out<=fetch_pc+4, instr_valid<=1, go to REQ.
  - On imem_rvalid with slot not free: store rdata and fetch_pc+4 in the hold buffer, go to HOLD.
- HOLD:
  - imem_req=0.
  - When stall=0: move the hold buffer to the outputs, instr_valid<=1, go to REQ.
- DRAIN:
  - imem_req=0. Wait for the orphaned response.
  - On imem_rvalid: discard it, go to REQ.
  - A further redirect in DRAIN only updates pc.

Redirect in any state:
- pc<=redirect_pc, instr_valid<=0, instr_out<=NOP_WORD, hold buffer cleared.
- Next state: WAIT->DRAIN, unless imem_rvalid arrives in the same cycle, in which case the data is dropped and the next state is REQ. HOLD->REQ. DRAIN->DRAIN. REQ as described above.

Timing and arithmetic:
- At most one outstanding request.
- Best-case throughput is one instruction per 2 cycles (grant in cycle n, rvalid in cycle n+1, output valid after the n+1 edge).
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- redirect_pc[1:0] is used unchanged; alignment is the decoder's responsibility.
- imem_rvalid outside WAIT or DRAIN is ignored.

Test Plan:
1. Reset: assert reset mid-WAIT -> outputs clear immediately without a clock edge; after release, imem_req=1, imem_addr=32'h0040_0000, instr_valid=0, instr_out=0.
2. Streaming: memory grants immediately and returns after 1 cycle with 0x20080005 then 0x20090007 -> instr_out shows 0x20080005/next_pc_out 0x00400004, then 0x20090007/0x00400008, with instr_valid pulses every 2 cycles.
3. Stall: hold stall=1 for 4 cycles while instr_valid=1, with the next response 0x01095020 arriving -> it enters HOLD, imem_req=0, outputs stay stable; one cycle after stall drops, instr_out=0x01095020.
4. Redirect in WAIT: redirect with redirect_pc=0x0040_0040 while a fetch is outstanding -> instr_valid=0 next cycle, the late response is discarded, the next imem_addr is 0x0040_0040, and the first valid next_pc_out is 0x0040_0044.
5. Simultaneous redirect, stall and rvalid in HOLD/WAIT -> redirect wins: output flushed, hold buffer empty, the following request goes to redirect_pc.
6. Wrap-around: RESET_PC=32'hFFFF_FFFC -> the second request address is 32'h0000_0000 and next_pc_out=0 for the first instruction.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC and issues one word fetch at a time. Output is registered, so best case is one instruction per two cycles.
// A stalled output slot parks one returned word in a hold buffer. Redirects flush that buffer and drop any in-flight fetch.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] next_pc_out,
    output logic        instr_valid,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_instr;
    logic [31:0] r_next_pc;
    logic        r_valid;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_next_pc;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_next_pc_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_hold_instr_nxt;
    logic [31:0] w_hold_next_pc_nxt;
    logic        w_slot_free;

    assign w_slot_free = !r_valid || !stall;

    assign imem_req    = (r_state == S_REQ) && !reset;
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign instr_out   = r_instr;
    assign next_pc_out = r_next_pc;
    assign instr_valid = r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_fetch_pc_nxt     = r_fetch_pc;
        w_instr_nxt        = r_instr;
        w_next_pc_nxt      = r_next_pc;
        w_valid_nxt        = r_valid;
        w_hold_instr_nxt   = r_hold_instr;
        w_hold_next_pc_nxt = r_hold_next_pc;

        // Consumed with nothing to replace it: next_pc_out intentionally keeps its value.
        if (r_valid && !stall) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_WORD;
        end

        if (redirect) begin
            w_pc_nxt           = redirect_pc;
            w_valid_nxt        = 1'b0;
            w_instr_nxt        = NOP_WORD;
            w_hold_instr_nxt   = '0;
            w_hold_next_pc_nxt = '0;
            unique case (r_state)
                S_REQ:   w_state_nxt = imem_gnt ? S_DRAIN : S_REQ;
                S_WAIT:  w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
                S_HOLD:  w_state_nxt = S_REQ;
                S_DRAIN: w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (imem_gnt) begin
                        w_fetch_pc_nxt = r_pc;
                        w_pc_nxt       = r_pc + 32'd4;
                        w_state_nxt    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (w_slot_free) begin
                            w_instr_nxt   = imem_rdata;
                            w_next_pc_nxt = r_fetch_pc + 32'd4;
                            w_valid_nxt   = 1'b1;
                            w_state_nxt   = S_REQ;
                        end else begin
                            w_hold_instr_nxt   = imem_rdata;
                            w_hold_next_pc_nxt = r_fetch_pc + 32'd4;
                            w_state_nxt        = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_instr_nxt        = r_hold_instr;
                        w_next_pc_nxt      = r_hold_next_pc;
                        w_valid_nxt        = 1'b1;
                        w_hold_instr_nxt   = '0;
                        w_hold_next_pc_nxt = '0;
                        w_state_nxt        = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_fetch_pc     <= RESET_PC;
            r_instr        <= NOP_WORD;
            r_next_pc      <= '0;
            r_valid        <= 1'b0;
            r_hold_instr   <= '0;
            r_hold_next_pc <= '0;
        end else begin
            r_pc           <= w_pc_nxt;
            r_fetch_pc     <= w_fetch_pc_nxt;
            r_instr        <= w_instr_nxt;
            r_next_pc      <= w_next_pc_nxt;
            r_valid        <= w_valid_nxt;
            r_hold_instr   <= w_hold_instr_nxt;
            r_hold_next_pc <= w_hold_next_pc_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: two fetch units share one stimulus stream; the second one resets near the top of the address space.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req,    w_imem_req;
    logic [31:0] imem_addr,   w_imem_addr;
    logic [31:0] instr_out,   w_instr_out;
    logic [31:0] next_pc_out, w_next_pc_out;
    logic        instr_valid, w_instr_valid;
    logic [31:0] pc_out,      w_pc_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .next_pc_out(next_pc_out), .instr_valid(instr_valid), .pc_out(pc_out)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_out(w_instr_out), .next_pc_out(w_next_pc_out), .instr_valid(w_instr_valid), .pc_out(w_pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then land on the next falling edge to sample.
    task automatic drv(input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdr, input logic [31:0] rpc);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        stall       = st;
        redirect    = rdr;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] npc);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        chk({tag, ".instr"}, instr_out, ins);
        chk({tag, ".npc"}, next_pc_out, npc);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.pc", pc_out, 32'h0040_0000);
        chk_out("rst", 1'b0, 32'h0, 32'h0);
        chk("rst.wrap_pc", w_pc_out, 32'hFFFF_FFFC);
        reset = 1'b0;
        #1;
        chk("rel.req", {31'd0, imem_req}, 32'd1);
        chk("rel.addr", imem_addr, 32'h0040_0000);
        chk("rel.wrap_addr", w_imem_addr, 32'hFFFF_FFFC);

        // streaming
        drv(1, 0, 0, 0, 0, 0);
        chk("s1.req", {31'd0, imem_req}, 32'd0);
        chk("s1.pc", pc_out, 32'h0040_0004);
        chk("s1.wrap_pc", w_pc_out, 32'h0000_0000);
        drv(0, 1, 32'h2008_0005, 0, 0, 0);
        chk_out("s2", 1'b1, 32'h2008_0005, 32'h0040_0004);
        chk("s2.addr", imem_addr, 32'h0040_0004);
        chk("s2.wrap_npc", w_next_pc_out, 32'h0000_0000);
        chk("s2.wrap_addr", w_imem_addr, 32'h0000_0000);
        chk("s2.wrap_req", {31'd0, w_imem_req}, 32'd1);
        drv(1, 0, 0, 0, 0, 0);
        chk_out("s3", 1'b0, 32'h0, 32'h0040_0004);
        drv(0, 1, 32'h2009_0007, 0, 0, 0);
        chk_out("s4", 1'b1, 32'h2009_0007, 32'h0040_0008);
        chk("s4.addr", imem_addr, 32'h0040_0008);

        // stall for four cycles while the next response lands in the hold buffer
        drv(1, 0, 0, 1, 0, 0);
        chk_out("st1", 1'b1, 32'h2009_0007, 32'h0040_0008);
        drv(0, 1, 32'h0109_5020, 1, 0, 0);
        chk("st2.req", {31'd0, imem_req}, 32'd0);
        chk_out("st2", 1'b1, 32'h2009_0007, 32'h0040_0008);
        drv(0, 0, 0, 1, 0, 0);
        chk("st3.req", {31'd0, imem_req}, 32'd0);
        drv(0, 0, 0, 1, 0, 0);
        chk_out("st4", 1'b1, 32'h2009_0007, 32'h0040_0008);
        drv(0, 0, 0, 0, 0, 0);
        chk_out("st5", 1'b1, 32'h0109_5020, 32'h0040_000C);
        chk("st5.addr", imem_addr, 32'h0040_000C);

        // redirect while a fetch is outstanding
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 32'h0040_0040);
        chk("rw1.valid", {31'd0, instr_valid}, 32'd0);
        chk("rw1.req", {31'd0, imem_req}, 32'd0);
        chk("rw1.pc", pc_out, 32'h0040_0040);
        drv(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk_out("rw2", 1'b0, 32'h0, 32'h0040_000C);
        chk("rw2.req", {31'd0, imem_req}, 32'd1);
        chk("rw2.addr", imem_addr, 32'h0040_0040);
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 1, 32'h0000_0013, 0, 0, 0);
        chk_out("rw3", 1'b1, 32'h0000_0013, 32'h0040_0044);

        // redirect + stall + rvalid while in HOLD
        drv(1, 0, 0, 1, 0, 0);
        drv(0, 1, 32'hAAAA_0001, 1, 0, 0);
        chk("rh1.req", {31'd0, imem_req}, 32'd0);
        drv(0, 1, 32'hAAAA_0001, 1, 1, 32'h0040_0100);
        chk_out("rh2", 1'b0, 32'h0, 32'h0040_0044);
        chk("rh2.req", {31'd0, imem_req}, 32'd1);
        chk("rh2.addr", imem_addr, 32'h0040_0100);
        drv(0, 0, 0, 0, 0, 0);
        chk_out("rh3", 1'b0, 32'h0, 32'h0040_0044);

        // redirect + stall + rvalid while in WAIT
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 1, 32'hBBBB_0002, 1, 1, 32'h0040_0200);
        chk_out("rv1", 1'b0, 32'h0, 32'h0040_0044);
        chk("rv1.req", {31'd0, imem_req}, 32'd1);
        chk("rv1.addr", imem_addr, 32'h0040_0200);
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 1, 32'h0000_0011, 0, 0, 0);
        chk_out("rv2", 1'b1, 32'h0000_0011, 32'h0040_0204);

        // asynchronous reset in the middle of WAIT
        drv(1, 0, 0, 0, 0, 0);
        imem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        chk_out("ar1", 1'b0, 32'h0, 32'h0);
        chk("ar1.req", {31'd0, imem_req}, 32'd0);
        chk("ar1.pc", pc_out, 32'h0040_0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar2.req", {31'd0, imem_req}, 32'd1);
        chk("ar2.addr", imem_addr, 32'h0040_0000);
        chk_out("ar2", 1'b0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
